// File: rtl/instr_seq_ctrl.sv
// Multi-cycle instruction sequencer for the non-pipelined core.
// Fetches over a req/gnt port, classifies the opcode into one-hot type
// enables, runs the data-memory handshake for loads/stores, retires the
// instruction (PC / instret / register-file write) and traps on illegal
// opcodes, memory timeouts and misaligned jump/branch targets.
module instr_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        SEQrst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        R_EN_o,
  output logic        I_EN_o,
  output logic        S_EN_o,
  output logic        SB_EN_o,
  output logic        U_EN_o,
  output logic        UJ_EN_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_gnt_i,
  input  logic        branch_taken_i,
  input  logic [31:0] target_pc_i,
  output logic        rf_we_o,
  output logic [31:0] pc_o,
  output logic [31:0] instret_o,
  output logic        trap_o,
  output logic [1:0]  trap_cause_o
);

  localparam int unsigned     TW      = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0]   TO_LAST = TW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Bit positions inside the packed enable vector {R,I,S,SB,U,UJ}
  localparam int unsigned EN_R  = 5;
  localparam int unsigned EN_I  = 4;
  localparam int unsigned EN_S  = 3;
  localparam int unsigned EN_SB = 2;
  localparam int unsigned EN_U  = 1;
  localparam int unsigned EN_UJ = 0;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_MISALGN = 2'b11;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instret_q, instret_d;
  logic [31:0]   instr_q, instr_d;
  logic [5:0]    en_q, en_d;
  logic [1:0]    cause_q, cause_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic [5:0]    dec_en;
  logic          is_load;
  logic          is_jalr;
  logic          take;
  logic          misaligned;
  logic          writes_rf;

  // Opcode classification of the latched instruction
  always_comb begin
    dec_en = '0;
    case (instr_q[6:0])
      OP_R:                      dec_en[EN_R]  = 1'b1;
      OP_IMM, OP_LOAD, OP_JALR:  dec_en[EN_I]  = 1'b1;
      OP_STORE:                  dec_en[EN_S]  = 1'b1;
      OP_BR:                     dec_en[EN_SB] = 1'b1;
      OP_LUI, OP_AUIPC:          dec_en[EN_U]  = 1'b1;
      OP_JAL:                    dec_en[EN_UJ] = 1'b1;
      default:                   dec_en        = '0;
    endcase
  end

  assign is_load    = (instr_q[6:0] == OP_LOAD);
  assign is_jalr    = (instr_q[6:0] == OP_JALR);
  assign take       = en_q[EN_UJ] | is_jalr | (en_q[EN_SB] & branch_taken_i);
  assign misaligned = take & (target_pc_i[1:0] != 2'b00);
  assign writes_rf  = en_q[EN_R] | en_q[EN_I] | en_q[EN_U] | en_q[EN_UJ];

  // State and datapath registers
  always_ff @(posedge clk_i or negedge SEQrst_i) begin
    if (!SEQrst_i) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      instret_q <= '0;
      instr_q   <= '0;
      en_q      <= '0;
      cause_q   <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      instr_q   <= instr_d;
      en_q      <= en_d;
      cause_q   <= cause_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Next-state, retirement and trap logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    instr_d   = instr_q;
    en_d      = en_q;
    cause_d   = cause_q;
    to_cnt_d  = to_cnt_q;
    rf_we_o   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        to_cnt_d = '0;
        state_d  = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_gnt_i) begin
          instr_d = imem_rdata_i;
          state_d = ST_DECODE;
        end else if (to_cnt_q == TO_LAST) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = ST_TRAP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_DECODE: begin
        if (dec_en == '0) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = ST_TRAP;
        end else begin
          en_d    = dec_en;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_load || en_q[EN_S]) begin
          to_cnt_d = '0;
          state_d  = ST_MEM;
        end else begin
          state_d  = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_gnt_i) begin
          state_d = ST_WB;
        end else if (to_cnt_q == TO_LAST) begin
          en_d    = '0;
          cause_d = CAUSE_TIMEOUT;
          state_d = ST_TRAP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_WB: begin
        en_d = '0;
        if (misaligned) begin
          cause_d = CAUSE_MISALGN;
          state_d = ST_TRAP;
        end else begin
          rf_we_o   = writes_rf;
          instret_d = instret_q + 32'd1;
          pc_d      = take ? target_pc_i : (pc_q + 32'd4);
          to_cnt_d  = '0;
          state_d   = ST_FETCH;
        end
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase
  end

  assign imem_req_o   = (state_q == ST_FETCH);
  assign imem_addr_o  = pc_q;
  assign instr_o      = instr_q;
  assign R_EN_o       = en_q[EN_R];
  assign I_EN_o       = en_q[EN_I];
  assign S_EN_o       = en_q[EN_S];
  assign SB_EN_o      = en_q[EN_SB];
  assign U_EN_o       = en_q[EN_U];
  assign UJ_EN_o      = en_q[EN_UJ];
  assign dmem_req_o   = (state_q == ST_MEM);
  assign dmem_we_o    = (state_q == ST_MEM) & en_q[EN_S];
  assign pc_o         = pc_q;
  assign instret_o    = instret_q;
  assign trap_o       = (state_q == ST_TRAP);
  assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Bench for instr_seq_ctrl: a transaction-level reference walks each
// instruction through its phases, publishing the outputs expected on every
// cycle; one compare process checks all outputs at each falling edge.
module tb_instr_seq_ctrl;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam int          TB_TO       = 8;

  logic        clk_i = 1'b0;
  logic        SEQrst_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] instr_o;
  logic        R_EN_o, I_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_gnt_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] target_pc_i = '0;
  logic        rf_we_o;
  logic [31:0] pc_o;
  logic [31:0] instret_o;
  logic        trap_o;
  logic [1:0]  trap_cause_o;

  instr_seq_ctrl #(
    .RESET_PC   (TB_RESET_PC),
    .MEM_TIMEOUT(TB_TO)
  ) dut (
    .clk_i         (clk_i),
    .SEQrst_i      (SEQrst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .R_EN_o        (R_EN_o),
    .I_EN_o        (I_EN_o),
    .S_EN_o        (S_EN_o),
    .SB_EN_o       (SB_EN_o),
    .U_EN_o        (U_EN_o),
    .UJ_EN_o       (UJ_EN_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .branch_taken_i(branch_taken_i),
    .target_pc_i   (target_pc_i),
    .rf_we_o       (rf_we_o),
    .pc_o          (pc_o),
    .instret_o     (instret_o),
    .trap_o        (trap_o),
    .trap_cause_o  (trap_cause_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural view of the sequencer
  logic [31:0] m_pc, m_instret, m_instr;
  logic        m_trap;
  logic [1:0]  m_cause;

  // Outputs expected during the current cycle
  logic        e_ireq, e_dreq, e_dwe, e_rfwe, e_trap;
  logic [31:0] e_iaddr, e_instr, e_pc, e_instret;
  logic [5:0]  e_en;
  logic [1:0]  e_cause;
  logic        chk_on = 1'b1;
  int          abort_at_mem = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Single compare process against the reference expectations
  always @(negedge clk_i) begin
    if (chk_on) begin
      chk("imem_req",  32'(imem_req_o), 32'(e_ireq));
      chk("imem_addr", imem_addr_o, e_iaddr);
      chk("instr",     instr_o, e_instr);
      chk("enables",   32'({R_EN_o, I_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o}), 32'(e_en));
      chk("dmem_req",  32'(dmem_req_o), 32'(e_dreq));
      chk("dmem_we",   32'(dmem_we_o), 32'(e_dwe));
      chk("rf_we",     32'(rf_we_o), 32'(e_rfwe));
      chk("pc",        pc_o, e_pc);
      chk("instret",   instret_o, e_instret);
      chk("trap",      32'(trap_o), 32'(e_trap));
      chk("cause",     32'(trap_cause_o), 32'(e_cause));
    end
  end

  // Class index 0..5 = R,I,S,SB,U,UJ; -1 = illegal
  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0110011:                         return 0;
      7'b0010011, 7'b0000011, 7'b1100111: return 1;
      7'b0100011:                         return 2;
      7'b1100011:                         return 3;
      7'b0110111, 7'b0010111:             return 4;
      7'b1101111:                         return 5;
      default:                            return -1;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
  endtask

  // Random activity on every input; phases override what they own
  task automatic noise();
    imem_gnt_i     = 1'($urandom_range(0, 1));
    imem_rdata_i   = $urandom;
    dmem_gnt_i     = 1'($urandom_range(0, 1));
    branch_taken_i = 1'($urandom_range(0, 1));
    target_pc_i    = $urandom;
  endtask

  task automatic set_idle();
    e_ireq = 1'b0; e_dreq = 1'b0; e_dwe = 1'b0; e_rfwe = 1'b0;
    e_iaddr = m_pc; e_pc = m_pc; e_instr = m_instr; e_instret = m_instret;
    e_en = '0; e_trap = m_trap; e_cause = m_cause;
  endtask

  task automatic do_reset();
    SEQrst_i = 1'b0;
    m_pc = TB_RESET_PC; m_instret = '0; m_instr = '0; m_trap = 1'b0; m_cause = '0;
    for (int i = 0; i < 3; i++) begin
      noise(); set_idle(); tick();
    end
    SEQrst_i = 1'b1;
    noise(); set_idle(); tick();   // boot cycle
  endtask

  task automatic trap_idle(input int n);
    for (int i = 0; i < n; i++) begin
      noise(); set_idle(); tick();
    end
  endtask

  // One instruction from fetch to retirement (or trap)
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic tk, input logic [31:0] tgt);
    int         cls;
    logic [5:0] en;
    logic       jump;
    for (int w = 0; ; w++) begin
      noise(); set_idle(); e_ireq = 1'b1;
      imem_gnt_i = (w == fw);
      if (w == fw) imem_rdata_i = ins;
      tick();
      if (w == fw) break;
      if (w == TB_TO - 1) begin m_trap = 1'b1; m_cause = 2'b10; return; end
    end
    m_instr = ins;
    cls = classify(ins[6:0]);
    noise(); set_idle(); tick();                 // decode
    if (cls < 0) begin m_trap = 1'b1; m_cause = 2'b01; return; end
    en = 6'b100000 >> cls;
    noise(); set_idle(); e_en = en; tick();      // execute
    if (ins[6:0] == 7'b0000011 || cls == 2) begin
      for (int w = 0; ; w++) begin
        if (w == abort_at_mem) return;
        noise(); set_idle(); e_en = en; e_dreq = 1'b1; e_dwe = (cls == 2);
        dmem_gnt_i = (w == mw);
        tick();
        if (w == mw) break;
        if (w == TB_TO - 1) begin m_trap = 1'b1; m_cause = 2'b10; return; end
      end
    end
    noise(); set_idle(); e_en = en;
    branch_taken_i = tk; target_pc_i = tgt;
    jump = (cls == 5) || (ins[6:0] == 7'b1100111) || (cls == 3 && tk);
    if (jump && tgt[1:0] != 2'b00) begin
      tick();
      m_trap = 1'b1; m_cause = 2'b11;
      return;
    end
    e_rfwe = (cls == 0 || cls == 1 || cls == 4 || cls == 5);
    tick();
    m_pc = jump ? tgt : m_pc + 32'd4;
    m_instret = m_instret + 32'd1;
  endtask

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 99);
    if (r < 4)      return TB_TO;
    else if (r < 9) return TB_TO - 1;
    else            return $urandom_range(0, 3);
  endfunction

  initial begin
    logic [6:0]  ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                             7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    logic [31:0] rnd, tgt;
    logic [6:0]  op;
    do_reset();

    // addi, zero-wait
    run_instr(32'h0050_0093, 0, 0, 1'b0, 32'h0);
    chk("t1_pc", pc_o, 32'h4);
    chk("t1_instret", instret_o, 32'h1);
    // sw with 3-cycle data wait
    run_instr(32'h0011_2023, 0, 3, 1'b0, 32'h0);
    chk("t2_pc", pc_o, 32'h8);
    // beq taken then not taken
    run_instr(32'h0000_0463, 1, 0, 1'b1, 32'h40);
    chk("t3_pc_taken", pc_o, 32'h40);
    run_instr(32'h0000_0463, 0, 0, 1'b0, 32'h80);
    chk("t3_pc_not", pc_o, 32'h44);
    chk("t3_instret", instret_o, 32'h4);
    // illegal opcode
    run_instr(32'h0000_007F, 0, 0, 1'b0, 32'h0);
    chk("t4_trap", 32'(trap_o), 32'h1);
    chk("t4_cause", 32'(trap_cause_o), 32'h1);
    trap_idle(6);

    // fetch timeout, then grant on the final allowed cycle
    do_reset();
    run_instr(32'h0050_0093, TB_TO, 0, 1'b0, 32'h0);
    chk("t5_cause", 32'(trap_cause_o), 32'h2);
    trap_idle(4);
    do_reset();
    run_instr(32'h0050_0093, TB_TO - 1, 0, 1'b0, 32'h0);
    chk("t5_edge_instret", instret_o, 32'h1);

    // misaligned jal target
    do_reset();
    run_instr(32'h0000_006F, 0, 0, 1'b0, 32'h42);
    chk("t6_cause", 32'(trap_cause_o), 32'h3);
    chk("t6_pc", pc_o, 32'h0);
    chk("t6_instret", instret_o, 32'h0);
    trap_idle(3);
    // PC wrap
    do_reset();
    run_instr(32'h0000_006F, 0, 0, 1'b0, 32'hFFFF_FFFC);
    run_instr(32'h0050_0093, 0, 0, 1'b0, 32'h0);
    chk("t6_wrap_pc", pc_o, 32'h0);
    chk("t6_wrap_instret", instret_o, 32'h2);

    // reset asserted in the middle of a load access
    do_reset();
    abort_at_mem = 1;
    run_instr(32'h0000_2083, 0, 5, 1'b0, 32'h0);
    abort_at_mem = -1;
    SEQrst_i = 1'b0;
    #1;
    chk("t7_dmem_req", 32'(dmem_req_o), 32'h0);
    chk("t7_i_en", 32'(I_EN_o), 32'h0);
    chk("t7_instr", instr_o, 32'h0);
    do_reset();

    // randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      rnd = $urandom;
      if ($urandom_range(0, 99) < 3) begin
        do op = 7'($urandom); while (classify(op) >= 0);
      end else begin
        op = ops[$urandom_range(0, 8)];
      end
      tgt = $urandom;
      if ($urandom_range(0, 99) < 92) tgt[1:0] = 2'b00;
      else if (tgt[1:0] == 2'b00) tgt[0] = 1'b1;
      run_instr({rnd[31:7], op}, rand_wait(), rand_wait(), 1'($urandom_range(0, 1)), tgt);
      if (m_trap) begin
        trap_idle(3);
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
